uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 113 +++++++++++
 tb/tb_uart_tx_serializer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter, LSB first. Accepts one byte per start pulse while idle and
// reports busy / frame-complete to the upstream send controllers.
module uart_tx_serializer #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar_envio,
  input  logic [7:0] dado_entrada,
  output logic       tx,
  output logic       ocupado,
  output logic       envio_concluido
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CntW         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_baud_cnt, w_baud_cnt_d;
  logic [2:0]      r_bit_idx, w_bit_idx_d;
  logic [7:0]      r_shift, w_shift_d;
  logic            r_tx, w_tx_d;
  logic            r_ocupado, w_ocupado_d;
  logic            r_concluido, w_concluido_d;
  logic            w_bit_done;
  logic [2:0]      w_bit_idx_inc;

  assign w_bit_done    = (r_baud_cnt == CntMax);
  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  // Reset drives tx high asynchronously so an abandoned frame never glitches low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_tx        <= 1'b1;
      r_ocupado   <= 1'b0;
      r_concluido <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_baud_cnt  <= w_baud_cnt_d;
      r_bit_idx   <= w_bit_idx_d;
      r_shift     <= w_shift_d;
      r_tx        <= w_tx_d;
      r_ocupado   <= w_ocupado_d;
      r_concluido <= w_concluido_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (iniciar_envio) w_state_d = StStart;
      StStart: if (w_bit_done) w_state_d = StData;
      StData:  if (w_bit_done && (r_bit_idx == 3'd7)) w_state_d = StStop;
      StStop:  if (w_bit_done) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_baud_cnt_d  = w_bit_done ? '0 : r_baud_cnt + CntW'(1);
    w_bit_idx_d   = r_bit_idx;
    w_shift_d     = r_shift;
    w_tx_d        = r_tx;
    w_ocupado_d   = r_ocupado;
    w_concluido_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_baud_cnt_d = '0;
        w_tx_d       = 1'b1;
        w_ocupado_d  = 1'b0;
        if (iniciar_envio) begin
          w_shift_d   = dado_entrada;
          w_bit_idx_d = '0;
          w_tx_d      = 1'b0;
          w_ocupado_d = 1'b1;
        end
      end
      StStart: begin
        if (w_bit_done) w_tx_d = r_shift[0];
      end
      StData: begin
        if (w_bit_done) begin
          w_bit_idx_d = w_bit_idx_inc;
          w_tx_d      = (r_bit_idx == 3'd7) ? 1'b1 : r_shift[w_bit_idx_inc];
        end
      end
      StStop: begin
        if (w_bit_done) begin
          w_tx_d        = 1'b1;
          w_ocupado_d   = 1'b0;
          w_concluido_d = 1'b1;
        end
      end
      default: begin
        w_tx_d      = 1'b1;
        w_ocupado_d = 1'b0;
      end
    endcase
  end

  assign tx              = r_tx;
  assign ocupado         = r_ocupado;
  assign envio_concluido = r_concluido;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: directed scenarios plus random traffic, every cycle
// compared against a frame-timing reference model.
module tb_uart_tx_serializer;

  localparam int N = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar_envio;
  logic [7:0] dado_entrada;
  logic       tx;
  logic       ocupado;
  logic       envio_concluido;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: a frame is just "byte b started at cycle E"; line value is a
  // function of elapsed cycles t = now - E.
  bit       m_busy = 1'b0;
  int       m_t    = 0;
  bit [7:0] m_byte = 8'h00;
  bit       m_done = 1'b0;
  int       m_accept_cyc = 0;

  uart_tx_serializer #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar_envio  (iniciar_envio),
    .dado_entrada   (dado_entrada),
    .tx             (tx),
    .ocupado        (ocupado),
    .envio_concluido(envio_concluido)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit exp_tx();
    int slot;
    if (!m_busy) return 1'b1;
    slot = m_t / N;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_byte[slot-1];
    return 1'b1;
  endfunction

  task automatic check_outputs();
    check_eq("tx", 32'(tx), 32'(exp_tx()));
    check_eq("ocupado", 32'(ocupado), 32'(m_busy));
    check_eq("concluido", 32'(envio_concluido), 32'(m_done));
  endtask

  // One clock: advance the model with the inputs seen on this edge, then compare.
  task automatic step();
    @(posedge clock);
    cyc++;
    m_done = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == 10 * N) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (iniciar_envio) begin
      m_busy       = 1'b1;
      m_t          = 0;
      m_byte       = dado_entrada;
      m_accept_cyc = cyc;
    end
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] b);
    iniciar_envio = 1'b1;
    dado_entrada  = b;
    step();
    iniciar_envio = 1'b0;
  endtask

  task automatic run_to_idle();
    while (m_busy) step();
  endtask

  initial begin
    int acc1;
    reset         = 1'b1;
    iniciar_envio = 1'b0;
    dado_entrada  = 8'h00;
    #12;
    check_outputs();
    reset = 1'b0;

    // Idle after reset.
    repeat (50) step();

    // Single frame 0xAC.
    send(8'hAC);
    run_to_idle();
    repeat (3) step();

    // Back-to-back 0x00 then 0xFF, second issued right after ocupado falls.
    send(8'h00);
    acc1 = m_accept_cyc;
    run_to_idle();
    send(8'hFF);
    check_eq("b2b_spacing", 32'(m_accept_cyc - acc1), 32'(10 * N + 1));
    run_to_idle();
    repeat (3) step();

    // Requests during a frame and on the STOP->IDLE edge are dropped.
    send(8'h55);
    repeat (39) step();
    send(8'h33);
    while (m_t < 10 * N - 1) step();
    send(8'h33);
    check_eq("no_second_frame", 32'(m_busy), 32'(0));
    repeat (20) step();

    // Asynchronous reset mid-frame.
    send(8'h0F);
    repeat (34) step();
    #2;
    reset = 1'b1;
    #1;
    m_busy = 1'b0;
    m_done = 1'b0;
    check_outputs();
    repeat (2) step();
    #2;
    reset = 1'b0;
    repeat (3) step();
    send(8'hA5);
    run_to_idle();
    repeat (2) step();

    // Input byte changes after acceptance have no effect.
    send(8'h3C);
    dado_entrada = 8'hC3;
    run_to_idle();
    repeat (2) step();

    // Random traffic with spurious requests sprinkled through each frame.
    for (int f = 0; f < 8; f++) begin
      send(8'($urandom_range(255)));
      while (m_busy) begin
        iniciar_envio = ($urandom_range(7) == 0);
        dado_entrada  = 8'($urandom_range(255));
        step();
      end
      iniciar_envio = 1'b0;
      repeat ($urandom_range(5)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
